// File: rtl/spm_ctx_sequencer.sv
// Context sequencer: loads context words into the scratchpad config buffer, then steps them at a dwell rate.
// Optional multi-pass looping (REWIND state, iter_i) is compiled in when SPM_SEQ_LOOP_EN is defined.
module spm_ctx_sequencer #(
  parameter int INST_W = 24,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [INST_W-1:0]        cfg_data_i,
  input  logic                     cfg_last_i,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         dwell_i,
  input  logic [CNT_W-1:0]         iter_i,
  output logic                     spm_init_o,
  output logic [INST_W-1:0]        spm_inst_o,
  output logic                     spm_run_o,
  output logic                     spm_rst_o,
  output logic [$clog2(DEPTH)-1:0] ctx_idx_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [2:0]               dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LOADED = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
`ifdef SPM_SEQ_LOOP_EN
  localparam logic [2:0] S_REWIND = 3'd4;
`endif

  logic [2:0]       state_q, state_d;
  logic [IDX_W:0]   word_cnt_q, word_cnt_d;
  logic [IDX_W:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [IDX_W-1:0] ctx_idx_q, ctx_idx_d;
  logic             err_q, err_d;
`ifdef SPM_SEQ_LOOP_EN
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] iter_q, iter_d;
`else
  logic             unused_iter;
  assign unused_iter = ^iter_i;
`endif

  logic              xfer;
  logic              init_c;
  logic [INST_W-1:0] inst_c;
  logic              run_c;
  logic              done_c;

  // Handshake: a word transfers on any cycle where cfg_valid_i && cfg_ready_o; the host
  // holds data/last stable while valid is high and ready is low. Ready is high only in IDLE/LOAD.
  assign cfg_ready_o = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign xfer        = cfg_valid_i && cfg_ready_o;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    run_cnt_d   = run_cnt_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    ctx_idx_d   = ctx_idx_q;
    err_d       = err_q;
`ifdef SPM_SEQ_LOOP_EN
    pass_d      = pass_q;
    iter_d      = iter_q;
`endif
    init_c      = 1'b0;
    inst_c      = '0;
    run_c       = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          init_c     = 1'b1;
          inst_c     = cfg_data_i;
          word_cnt_d = (IDX_W+1)'(1);
          state_d    = cfg_last_i ? S_LOADED : S_LOAD;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          // A word beyond buffer capacity is dropped and ends the load.
          if (word_cnt_q == DEPTH_C) begin
            err_d   = 1'b1;
            state_d = S_LOADED;
          end else begin
            init_c     = 1'b1;
            inst_c     = cfg_data_i;
            word_cnt_d = word_cnt_q + (IDX_W+1)'(1);
            if (cfg_last_i) state_d = S_LOADED;
          end
        end
      end

      S_LOADED: begin
        if (start_i) begin
          state_d     = S_RUN;
          dwell_d     = (dwell_i == '0) ? CNT_W'(1) : dwell_i;
          run_cnt_d   = '0;
          dwell_cnt_d = '0;
`ifdef SPM_SEQ_LOOP_EN
          iter_d      = (iter_i == '0) ? CNT_W'(1) : iter_i;
          pass_d      = '0;
`endif
        end
      end

      S_RUN: begin
        // dwell_cnt_q is the number of cycles left before the next pulse slot.
        if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - CNT_W'(1);
        end else if (run_cnt_q < word_cnt_q) begin
          run_c       = 1'b1;
          ctx_idx_d   = run_cnt_q[IDX_W-1:0];
          run_cnt_d   = run_cnt_q + (IDX_W+1)'(1);
          dwell_cnt_d = dwell_q - CNT_W'(1);
        end else begin
`ifdef SPM_SEQ_LOOP_EN
          if ((pass_q + CNT_W'(1)) < iter_q) begin
            state_d = S_REWIND;
            pass_d  = pass_q + CNT_W'(1);
          end else begin
            done_c     = 1'b1;
            state_d    = S_IDLE;
            word_cnt_d = '0;
            run_cnt_d  = '0;
            ctx_idx_d  = '0;
          end
`else
          done_c     = 1'b1;
          state_d    = S_IDLE;
          word_cnt_d = '0;
          run_cnt_d  = '0;
          ctx_idx_d  = '0;
`endif
        end
      end

`ifdef SPM_SEQ_LOOP_EN
      S_REWIND: begin
        // Scratchpad counter rewinds this cycle; the next RUN cycle pulses context 0.
        state_d     = S_RUN;
        run_cnt_d   = '0;
        dwell_cnt_d = '0;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      run_cnt_q   <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      ctx_idx_q   <= '0;
      err_q       <= 1'b0;
`ifdef SPM_SEQ_LOOP_EN
      pass_q      <= '0;
      iter_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      run_cnt_q   <= run_cnt_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      ctx_idx_q   <= ctx_idx_d;
      err_q       <= err_d;
`ifdef SPM_SEQ_LOOP_EN
      pass_q      <= pass_d;
      iter_q      <= iter_d;
`endif
    end
  end

  assign spm_init_o  = init_c;
  assign spm_inst_o  = inst_c;
  assign spm_run_o   = run_c;
  assign done_o      = done_c;
  assign ctx_idx_o   = ctx_idx_q;
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

`ifdef SPM_SEQ_LOOP_EN
  // Never rewind the scratchpad while the sequencer itself is being reset.
  assign spm_rst_o = (state_q == S_REWIND) && !rst;
`else
  assign spm_rst_o = 1'b0;
`endif

endmodule
